// File: rtl/bus_decoder_ws.sv
// rtl/bus_decoder_ws.sv - system-bus address decoder with per-region wait states
// Registered one-hot chip selects, wait-state countdown, ready/bus_error completion pulses.
module bus_decoder_ws #(
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_REGIONS = 4,
  parameter int REGION_BITS = 4,
  parameter int WAIT_BITS   = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ADDR_WIDTH-1:0]              address_bus,
  input  logic                               read,
  input  logic                               write,
  input  logic [NUM_REGIONS*REGION_BITS-1:0] region_base,
  input  logic [NUM_REGIONS*REGION_BITS-1:0] region_mask,
  input  logic [NUM_REGIONS*WAIT_BITS-1:0]   region_wait,
  output logic [NUM_REGIONS-1:0]             cs,
  output logic                               slave_rd,
  output logic                               slave_wr,
  output logic                               ready,
  output logic                               bus_error,
  output logic                               busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_ERROR,
    S_RELEASE
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_REGIONS-1:0] cs_q, cs_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic [WAIT_BITS-1:0]   cnt_q, cnt_d;

  logic [REGION_BITS-1:0] top_bits;
  logic [NUM_REGIONS-1:0] hit_sel;
  logic [WAIT_BITS-1:0]   sel_wait;
  logic                   hit_found;
  logic                   unused_addr_lo;

  assign top_bits       = address_bus[ADDR_WIDTH-1 -: REGION_BITS];
  assign unused_addr_lo = ^address_bus[ADDR_WIDTH-REGION_BITS-1:0];

  // Priority decode: the first (lowest-index) enabled region that matches wins.
  always_comb begin
    hit_sel   = '0;
    sel_wait  = '0;
    hit_found = 1'b0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (!hit_found &&
          (region_mask[i*REGION_BITS +: REGION_BITS] != '0) &&
          (((top_bits ^ region_base[i*REGION_BITS +: REGION_BITS]) &
            region_mask[i*REGION_BITS +: REGION_BITS]) == '0)) begin
        hit_sel[i] = 1'b1;
        sel_wait   = region_wait[i*WAIT_BITS +: WAIT_BITS];
        hit_found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cs_d      = cs_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    cnt_d     = cnt_q;
    ready     = 1'b0;
    bus_error = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read && write) begin
          state_d = S_ERROR;
        end else if (read ^ write) begin
          if (hit_found) begin
            state_d = S_ACCESS;
            cs_d    = hit_sel;
            rd_d    = read;
            wr_d    = write;
            cnt_d   = sel_wait;
          end else begin
            state_d = S_ERROR;
          end
        end
      end
      S_ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WAIT_BITS'(1);
        end else begin
          ready   = 1'b1;
          state_d = S_RELEASE;
          cs_d    = '0;
          rd_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      S_ERROR: begin
        ready     = 1'b1;
        bus_error = 1'b1;
        state_d   = S_RELEASE;
      end
      S_RELEASE: begin
        // Wait for the Cpu to drop its request so a held level cannot re-trigger.
        if (!read && !write) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cs_q    <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cs       = cs_q;
  assign slave_rd = rd_q;
  assign slave_wr = wr_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_decoder_ws.sv
// tb/tb_bus_decoder_ws.sv - self-checking bench for bus_decoder_ws
// Directed scenarios plus random transactions checked against a transaction-level model.
module tb_bus_decoder_ws;

  logic        clk;
  logic        reset;
  logic [15:0] address_bus;
  logic        read;
  logic        write;
  logic [7:0]  region_base;
  logic [7:0]  region_mask;
  logic [5:0]  region_wait;
  logic [1:0]  cs;
  logic        slave_rd;
  logic        slave_wr;
  logic        ready;
  logic        bus_error;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int cfg_base [2] = '{0, 9};
  int cfg_mask [2] = '{8, 15};
  int cfg_wait [2] = '{0, 2};

  bus_decoder_ws #(
    .ADDR_WIDTH (16),
    .NUM_REGIONS(2),
    .REGION_BITS(4),
    .WAIT_BITS  (3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address_bus(address_bus),
    .read       (read),
    .write      (write),
    .region_base(region_base),
    .region_mask(region_mask),
    .region_wait(region_wait),
    .cs         (cs),
    .slave_rd   (slave_rd),
    .slave_wr   (slave_wr),
    .ready      (ready),
    .bus_error  (bus_error),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_region(input logic [15:0] a);
    int top;
    top = int'(a) / 4096;
    for (int i = 0; i < 2; i++) begin
      if (cfg_mask[i] != 0 && ((top ^ cfg_base[i]) & cfg_mask[i]) == 0) return i;
    end
    return -1;
  endfunction

  // Observed vector: {cs[1:0], slave_rd, slave_wr, ready, bus_error, busy}
  task automatic check(input string tag, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {cs, slave_rd, slave_wr, ready, bus_error, busy};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE back to IDLE, every cycle checked against the model.
  task automatic run_txn(input logic [15:0] addr, input logic rd, input logic wr,
                         input int hold, input bit swap, input logic [15:0] alt_addr,
                         input string tag);
    int         region;
    int         wt;
    logic [1:0] oh;
    @(negedge clk);
    address_bus = addr;
    read        = rd;
    write       = wr;
    region      = (rd && wr) ? -1 : model_region(addr);
    if (region < 0) begin
      @(negedge clk);
      check({tag, "_err"}, 7'b00_00_111);
    end else begin
      wt = cfg_wait[region];
      oh = (region == 0) ? 2'b01 : 2'b10;
      for (int k = 0; k <= wt; k++) begin
        @(negedge clk);
        check($sformatf("%s_acc%0d", tag, k), {oh, rd, wr, (k == wt), 1'b0, 1'b1});
        if (swap) address_bus = alt_addr;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      check($sformatf("%s_rel%0d", tag, h), 7'b00_00_001);
    end
    read  = 1'b0;
    write = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, 7'b00_00_000);
  endtask

  initial begin
    reset       = 1'b1;
    address_bus = 16'h0000;
    read        = 1'b0;
    write       = 1'b0;
    region_base = {4'b1001, 4'b0000};
    region_mask = {4'b1111, 4'b1000};
    region_wait = {3'd2, 3'd0};

    #1;
    check("reset_async", 7'b00_00_000);
    @(negedge clk);
    check("reset_held", 7'b00_00_000);
    reset = 1'b0;
    @(negedge clk);
    check("idle_quiet", 7'b00_00_000);

    run_txn(16'h0123, 1'b1, 1'b0, 0, 1'b0, 16'h0000, "ram_read");
    run_txn(16'h9000, 1'b0, 1'b1, 3, 1'b0, 16'h0000, "diodes_write_held");
    run_txn(16'hC000, 1'b1, 1'b0, 2, 1'b0, 16'h0000, "unmapped_read");
    run_txn(16'h0000, 1'b1, 1'b1, 1, 1'b0, 16'h0000, "rd_and_wr");
    run_txn(16'h9000, 1'b1, 1'b0, 0, 1'b1, 16'h0000, "addr_switch");
    run_txn(16'h7FFF, 1'b0, 1'b1, 0, 1'b0, 16'h0000, "ram_edge");
    run_txn(16'h8FFF, 1'b1, 1'b0, 0, 1'b0, 16'h0000, "below_diodes");

    // Reset in the middle of a Diodes access, while the wait counter sits at 1.
    @(negedge clk);
    address_bus = 16'h9000;
    read        = 1'b1;
    @(negedge clk);
    check("mid_acc_w2", 7'b10_10_001);
    @(negedge clk);
    check("mid_acc_w1", 7'b10_10_001);
    #2 reset = 1'b1;
    #1;
    check("reset_mid_access", 7'b00_00_000);
    read = 1'b0;
    @(negedge clk);
    check("reset_mid_held", 7'b00_00_000);
    reset = 1'b0;
    run_txn(16'h0001, 1'b1, 1'b0, 0, 1'b0, 16'h0000, "post_reset_read");

    for (int n = 0; n < 40; n++) begin
      logic [15:0] a;
      logic [1:0]  op;
      a  = 16'($urandom);
      op = 2'($urandom_range(1, 3));
      run_txn(a, op[0], op[1], int'($urandom_range(0, 3)), 1'b1, 16'($urandom),
              $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
